// File: rtl/modn_down_chain_pkg.sv
// modn_pkg: shared types and helpers for the mod-N down-counter chain
//   state_t      FSM state {IDLE, RUN}
//   digit_width  bits needed for one base-N digit
//   all_zero     zero-detect over a (zero-extended) packed count
package modn_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    function automatic int digit_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic logic all_zero(input logic [63:0] v);
        return v == '0;
    endfunction
endpackage

// File: rtl/modn_down_chain_if.sv
// modn_down_chain_if: control/status bundle of the mod-N down counter
//   master: drives load, load_val, start, enable, auto_reload; observes count, busy, done, tc
//   slave : the counter side of the same signals
interface modn_down_chain_if import modn_pkg::*; #(
    parameter int N      = 10,
    parameter int DIGITS = 4,
    parameter int WIDTH  = digit_width(N)
) ();
    logic                    load;
    logic [DIGITS*WIDTH-1:0] load_val;
    logic                    start;
    logic                    enable;
    logic                    auto_reload;
    logic [DIGITS*WIDTH-1:0] count;
    logic                    busy;
    logic                    done;
    logic                    tc;
    modport master (
        output load, load_val, start, enable, auto_reload,
        input  count, busy, done, tc
    );
    modport slave (
        input  load, load_val, start, enable, auto_reload,
        output count, busy, done, tc
    );
endinterface

// File: rtl/modn_down_chain_digit.sv
// modn_down_digit: one base-N down-counting digit with borrow chaining
//   load/load_digit     synchronous preload (already clamped to N-1)
//   dec                 decrement this edge; 0 wraps to N-1
//   reload/reload_digit restart value after expiry in auto-reload mode
//   digit, is_zero      current value and its zero flag
//   borrow_out          dec & digit==0, feeds the next digit's dec
module modn_down_digit #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_digit,
    input  logic             dec,
    input  logic             reload,
    input  logic [WIDTH-1:0] reload_digit,
    output logic [WIDTH-1:0] digit,
    output logic             borrow_out,
    output logic             is_zero
);
    logic [WIDTH-1:0] digit_q, digit_d;
    always_comb
        digit_d = load   ? load_digit :
                  reload ? reload_digit :
                  dec    ? (is_zero ? WIDTH'(N - 1) : digit_q - WIDTH'(1)) : digit_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) digit_q <= '0;
        else          digit_q <= digit_d;
    assign is_zero    = digit_q == '0;
    assign borrow_out = dec & is_zero;
    assign digit      = digit_q;
endmodule

// File: rtl/modn_down_chain.sv
// modn_down_chain: programmable multi-digit mod-N down counter / interval timer
//   clk, reset_n  clock and asynchronous active-low reset
//   bus (slave)   load/load_val/start/enable/auto_reload in; count/busy/done/tc out
module modn_down_chain import modn_pkg::*; #(
    parameter int N      = 10,
    parameter int DIGITS = 4,
    parameter int WIDTH  = digit_width(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    modn_down_chain_if.slave   bus
);
    state_t                  state_q, state_d;
    logic [DIGITS*WIDTH-1:0] reload_q, reload_d, clamp_val, count;
    logic                    done_q, done_d;
    logic [DIGITS-1:0]       is_zero;
    logic [DIGITS:0]         bchain;
    logic                    run, tc, one, expire;
    assign run = state_q == RUN;
    assign tc  = all_zero(64'(count));
    // count == 1: the next enabled decrement reaches zero
    assign one    = (count[WIDTH-1:0] == WIDTH'(1)) && &(is_zero | DIGITS'(1));
    assign expire = run & bus.enable & one;
    assign bchain[0] = run & bus.enable;
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign clamp_val[i*WIDTH +: WIDTH] =
            (32'(bus.load_val[i*WIDTH +: WIDTH]) >= 32'(N)) ? WIDTH'(N - 1) : bus.load_val[i*WIDTH +: WIDTH];
        // a borrow out of the top digit means the whole count is zero: that edge reloads instead
        modn_down_digit #(.N(N), .WIDTH(WIDTH)) u_digit (
            .clk          (clk),
            .reset_n      (reset_n),
            .load         (bus.load),
            .load_digit   (clamp_val[i*WIDTH +: WIDTH]),
            .dec          (bchain[i]),
            .reload       (bchain[DIGITS]),
            .reload_digit (reload_q[i*WIDTH +: WIDTH]),
            .digit        (count[i*WIDTH +: WIDTH]),
            .borrow_out   (bchain[i+1]),
            .is_zero      (is_zero[i])
        );
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q  <= IDLE;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    always_comb begin
        state_d  = bus.load ? IDLE :
                   !run     ? ((bus.start && !tc) ? RUN : IDLE) :
                   (expire && !bus.auto_reload) ? IDLE : RUN;
        done_d   = !bus.load && ((!run && bus.start && tc) || expire);
        reload_d = bus.load ? clamp_val : reload_q;
    end
    always_comb begin
        bus.busy  = run;
        bus.done  = done_q;
        bus.tc    = tc;
        bus.count = count;
    end
endmodule

// File: tb/tb_modn_down_chain.sv
// tb_modn_down_chain: integer-level model plus directed vectors for modn_down_chain
module tb_modn_down_chain;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   total = 0, passed = 0, nd;
    int   mc = 0, mr = 0;
    bit   mrun = 1'b0, mdone = 1'b0;
    int   e4[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    int   p5[4] = '{1, 0, 0, 1};
    int   e5[4] = '{4, 4, 4, 3};

    always #5 clk = ~clk;

    modn_down_chain_if #(.N(10), .DIGITS(2)) bus ();
    modn_down_chain #(.N(10), .DIGITS(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    endtask

    function automatic int clampv(input logic [7:0] v);
        int acc = 0, p = 1, d;
        for (int k = 0; k < 2; k++) begin
            d = int'(v[4*k +: 4]);
            if (d > 9) d = 9;
            acc += d * p;
            p *= 10;
        end
        return acc;
    endfunction

    function automatic logic [7:0] pack(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'((v / 10) % 10);
        return r;
    endfunction

    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mc <= 0; mr <= 0; mrun <= 0; mdone <= 0;
        end else if (bus.load) begin
            mc <= clampv(bus.load_val); mr <= clampv(bus.load_val); mrun <= 0; mdone <= 0;
        end else if (!mrun) begin
            mdone <= bus.start && mc == 0;
            mrun  <= bus.start && mc != 0;
        end else if (!bus.enable) begin
            mdone <= 0;
        end else if (mc == 0) begin
            mc <= mr; mdone <= 0;
        end else begin
            mc <= mc - 1;
            mdone <= mc == 1;
            if (mc == 1 && !bus.auto_reload) mrun <= 0;
        end

    always @(negedge clk) begin
        chk("m_count", 32'(bus.count), 32'(pack(mc)));
        chk("m_busy", 32'(bus.busy), 32'(mrun));
        chk("m_done", 32'(bus.done), 32'(mdone));
        chk("m_tc", 32'(bus.tc), 32'(mc == 0));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_v(input logic [7:0] v);
        bus.load = 1'b1; bus.load_val = v;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.load = 0; bus.load_val = 0; bus.start = 0; bus.enable = 0; bus.auto_reload = 0;
        reset_n = 1'b0;
        #1;
        chk("rst_count", 32'(bus.count), 32'h00);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_tc", 32'(bus.tc), 1);
        step();
        reset_n = 1'b1;
        // 1: 25 down to 00
        load_v(8'h25);
        chk("t1_load", 32'(bus.count), 32'h25);
        bus.start = 1; bus.enable = 1;
        step();
        bus.start = 0;
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_nodec", 32'(bus.count), 32'h25);
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.done) nd++;
        end
        chk("t1_end_count", 32'(bus.count), 32'h00);
        chk("t1_end_done", 32'(bus.done), 1);
        chk("t1_end_busy", 32'(bus.busy), 0);
        chk("t1_done_once", nd, 1);
        step();
        chk("t1_done_drop", 32'(bus.done), 0);
        // 2: borrow 10 -> 09
        bus.enable = 0;
        load_v(8'h10);
        bus.start = 1;
        step();
        bus.start = 0; bus.enable = 1;
        step();
        bus.enable = 0;
        chk("t2_borrow", 32'(bus.count), 32'h09);
        load_v(8'h00);
        chk("t2_tc", 32'(bus.tc), 1);
        chk("t2_abort_busy", 32'(bus.busy), 0);
        // 3: clamp
        load_v(8'hFC);
        chk("t3_clamp", 32'(bus.count), 32'h99);
        // 4: auto reload period 4
        bus.auto_reload = 1;
        load_v(8'h03);
        bus.start = 1;
        step();
        bus.start = 0; bus.enable = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t4_count", 32'(bus.count), 32'(e4[i]));
            chk("t4_done", 32'(bus.done), 32'(e4[i] == 0));
            chk("t4_busy", 32'(bus.busy), 1);
        end
        bus.enable = 0; bus.auto_reload = 0;
        load_v(8'h00);
        // 5: enable gating, then start at zero
        load_v(8'h05);
        bus.start = 1;
        step();
        bus.start = 0;
        for (int i = 0; i < 4; i++) begin
            bus.enable = p5[i][0];
            step();
            chk("t5_gate", 32'(bus.count), 32'(e5[i]));
        end
        bus.enable = 0;
        load_v(8'h00);
        bus.start = 1;
        step();
        bus.start = 0;
        chk("t5_zero_done", 32'(bus.done), 1);
        chk("t5_zero_busy", 32'(bus.busy), 0);
        step();
        chk("t5_zero_drop", 32'(bus.done), 0);
        chk("t5_zero_idle", 32'(bus.busy), 0);
        // 6: async reset mid-run, load mid-run
        load_v(8'h18);
        bus.start = 1;
        step();
        bus.start = 0; bus.enable = 1;
        step();
        bus.enable = 0;
        chk("t6_pre", 32'(bus.count), 32'h17);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(bus.count), 32'h00);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_done", 32'(bus.done), 0);
        step();
        reset_n = 1'b1;
        load_v(8'h30);
        bus.start = 1;
        step();
        bus.start = 0; bus.enable = 1;
        step();
        chk("t6_run", 32'(bus.count), 32'h29);
        load_v(8'h42);
        bus.enable = 0;
        chk("t6_load_count", 32'(bus.count), 32'h42);
        chk("t6_load_busy", 32'(bus.busy), 0);
        chk("t6_load_done", 32'(bus.done), 0);
        step();
        chk("t6_after_done", 32'(bus.done), 0);
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
